i2s_slave: RTL and testbench

//  Slave-mode I2S transceiver: the responder end of the link our i2s2 master drives. lrck and sclk
//  are inputs; the block deserializes stereo samples from sdata_in and serializes stereo samples

---
 rtl/i2s_slave.sv | 157 +++++++++++++++
 tb/tb_i2s_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave.sv
// Slave-mode I2S transceiver: sclk/lrck from an external master are
// oversampled in the clk domain; stereo words deserialized and serialized.
module i2s_slave #(
   parameter int DATA_BITS = 24,
   parameter int CNT_BITS  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sclk_in,
   input  logic                 lrck_in,
   input  logic                 sdata_in,
   output logic                 sdata_out,
   input  logic [DATA_BITS-1:0] tx_data_l,
   input  logic [DATA_BITS-1:0] tx_data_r,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data_l,
   output logic [DATA_BITS-1:0] rx_data_r,
   output logic                 rx_valid,
   output logic                 frame_err
);

   typedef enum logic {SYNC, RUN} state_t;

   localparam logic [CNT_BITS-1:0] DBITS = CNT_BITS'(DATA_BITS);
   localparam logic [CNT_BITS-1:0] LAST  = CNT_BITS'(DATA_BITS - 1);
   localparam logic [CNT_BITS-1:0] CMAX  = '1;

   state_t state, state_nx;

   logic [1:0] sclk_q, lrck_q, sdat_q;
   logic       sclk_d;
   logic       sclk_s, lrck_s, sdat_s;
   logic       rise, fall;
   logic       lr_edge, lr_fall, lr_rise;
   logic       cap, done, done_l, done_r, short_slot;
   logic       run, lrck_prev, l_ok;

   logic [CNT_BITS-1:0]  bit_cnt;
   logic [DATA_BITS-2:0] rx_shift;
   logic [DATA_BITS-1:0] word;
   logic [DATA_BITS-1:0] l_hold;
   logic [DATA_BITS-1:0] hold_r;
   logic [DATA_BITS-1:0] tx_shift;

   assign sclk_s = sclk_q[1];
   assign lrck_s = lrck_q[1];
   assign sdat_s = sdat_q[1];

   assign rise = sclk_s & ~sclk_d;
   assign fall = ~sclk_s & sclk_d;
   assign run  = (state == RUN);

   assign lr_edge = rise & (lrck_s != lrck_prev);
   assign lr_fall = lr_edge & ~lrck_s;
   assign lr_rise = lr_edge & lrck_s;

   // The edge rise still carries the last bit of a DATA_BITS-long slot
   assign cap    = rise & (bit_cnt < DBITS);
   assign done   = cap & (bit_cnt == LAST);
   assign done_l = done & ~lrck_prev & run;
   assign done_r = done & lrck_prev & run;
   assign word   = {rx_shift, sdat_s};

   assign short_slot = lr_edge & run & (bit_cnt < LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_q <= '0;
         lrck_q <= '0;
         sdat_q <= '0;
         sclk_d <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[0], sclk_in};
         lrck_q <= {lrck_q[0], lrck_in};
         sdat_q <= {sdat_q[0], sdata_in};
         sclk_d <= sclk_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SYNC;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         SYNC:    if (lr_fall) state_nx = RUN;
         RUN:     state_nx = RUN;
         default: state_nx = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt   <= '0;
         lrck_prev <= 1'b0;
         rx_shift  <= '0;
      end else if (rise) begin
         if (cap) rx_shift <= word[DATA_BITS-2:0];
         if (lr_edge) begin
            bit_cnt   <= '0;
            lrck_prev <= lrck_s;
         end else if (bit_cnt != CMAX) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Left word is parked until its right partner completes the frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         l_hold    <= '0;
         l_ok      <= 1'b0;
         rx_data_l <= '0;
         rx_data_r <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= short_slot;
         if (lr_fall) l_ok <= 1'b0;
         if (done_l) begin
            l_hold <= word;
            l_ok   <= 1'b1;
         end
         if (done_r && l_ok) begin
            rx_data_l <= l_hold;
            rx_data_r <= word;
            rx_valid  <= 1'b1;
            l_ok      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_r    <= '0;
         tx_shift  <= '0;
         tx_ready  <= 1'b0;
         sdata_out <= 1'b0;
      end else begin
         tx_ready <= 1'b0;
         if (lr_fall) begin
            hold_r   <= tx_data_r;
            tx_shift <= tx_data_l;
            tx_ready <= 1'b1;
         end else if (lr_rise && run) begin
            tx_shift <= hold_r;
         end else if (fall) begin
            sdata_out <= run ? tx_shift[DATA_BITS-1] : 1'b0;
            tx_shift  <= {tx_shift[DATA_BITS-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_i2s_slave.sv
// Directed bench for i2s_slave: a bench-side I2S master drives sclk/lrck
// and data, captures sdata_out, and counts the DUT's strobe outputs.
module tb_i2s_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk_in, lrck_in, sd_drv, loop;
   logic        sdata_in, sdata_out;
   logic [23:0] tx_data_l, tx_data_r;
   logic [23:0] rx_data_l, rx_data_r;
   logic        tx_ready, rx_valid, frame_err;

   int checks = 0;
   int failures = 0;
   int n_rxv = 0;
   int n_txr = 0;
   int n_fe = 0;

   logic        pend;
   logic [30:0] cap_l, cap_r;

   always #5 clk = ~clk;

   assign sdata_in = loop ? sdata_out : sd_drv;

   i2s_slave #(.DATA_BITS(24), .CNT_BITS(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk_in   (sclk_in),
      .lrck_in   (lrck_in),
      .sdata_in  (sdata_in),
      .sdata_out (sdata_out),
      .tx_data_l (tx_data_l),
      .tx_data_r (tx_data_r),
      .tx_ready  (tx_ready),
      .rx_data_l (rx_data_l),
      .rx_data_r (rx_data_r),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always @(negedge clk) begin
      if (rx_valid)  n_rxv++;
      if (tx_ready)  n_txr++;
      if (frame_err) n_fe++;
   end

   function automatic logic bitof(input logic [23:0] w, input int j);
      return (j < 24) ? w[23-j] : 1'b0;
   endfunction

   // One slot of the master: lrck and data change on sclk fall (16 clk/sclk)
   task automatic run_slot(input logic lr, input logic [23:0] w, input int len);
      logic [30:0] v;
      v = '0;
      for (int i = 0; i < len; i++) begin
         sclk_in = 1'b0;
         lrck_in = lr;
         sd_drv  = (i == 0) ? pend : bitof(w, i - 1);
         repeat (8) @(posedge clk);
         #1;
         sclk_in = 1'b1;
         if (i > 0) v = {v[29:0], sdata_out};
         repeat (8) @(posedge clk);
         #1;
      end
      pend = bitof(w, len - 1);
      if (lr) cap_r = v;
      else    cap_l = v;
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                             input int len_l, input int len_r);
      run_slot(1'b0, l, len_l);
      run_slot(1'b1, r, len_r);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      sclk_in = 1'b0;
      lrck_in = 1'b0;
      sd_drv = 1'b0;
      loop = 1'b0;
      pend = 1'b0;
      tx_data_l = 24'hA5A5A5;
      tx_data_r = 24'h5A5A5A;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (rx_data_l !== 24'h0 || rx_data_r !== 24'h0) begin
         failures++;
         $display("FAIL reset_rx got %h/%h want 0/0", rx_data_l, rx_data_r);
      end
      checks++;
      if ({sdata_out, tx_ready, rx_valid, frame_err} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags got %b want 0000",
                  {sdata_out, tx_ready, rx_valid, frame_err});
      end
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_frames();
      int rv0, tr0, fe0;
      logic [23:0] ls [3];
      logic [23:0] rs [3];
      ls[0] = 24'h111111; rs[0] = 24'h222222;
      ls[1] = 24'h0F0F0F; rs[1] = 24'hF0F0F0;
      ls[2] = 24'hFFFFFF; rs[2] = 24'h000001;
      rv0 = n_rxv; tr0 = n_txr; fe0 = n_fe;
      run_slot(1'b1, 24'h654321, 32);
      checks++;
      if (n_rxv != rv0 || n_txr != tr0) begin
         failures++;
         $display("FAIL sync_quiet got rxv=%0d txr=%0d want 0 0",
                  n_rxv - rv0, n_txr - tr0);
      end
      for (int f = 0; f < 3; f++) begin
         send_frame(ls[f], rs[f], 32, 32);
         checks++;
         if (n_rxv - rv0 != f + 1) begin
            failures++;
            $display("FAIL frame%0d_rxv got %0d want %0d", f, n_rxv - rv0, f + 1);
         end
         checks++;
         if (rx_data_l !== ls[f] || rx_data_r !== rs[f]) begin
            failures++;
            $display("FAIL frame%0d_data got %h/%h want %h/%h",
                     f, rx_data_l, rx_data_r, ls[f], rs[f]);
         end
      end
      checks++;
      if (n_fe != fe0) begin
         failures++;
         $display("FAIL frames_ferr got %0d want 0", n_fe - fe0);
      end
   endtask

   task automatic test_rx_pattern();
      int fe0;
      fe0 = n_fe;
      send_frame(24'hABCDEF, 24'h123456, 32, 32);
      checks++;
      if (rx_data_l !== 24'hABCDEF || rx_data_r !== 24'h123456) begin
         failures++;
         $display("FAIL rx_pattern got %h/%h want abcdef/123456",
                  rx_data_l, rx_data_r);
      end
      checks++;
      if (n_fe != fe0) begin
         failures++;
         $display("FAIL rx_pattern_ferr got %0d want 0", n_fe - fe0);
      end
   endtask

   task automatic test_sclk_stop();
      int rv0, tr0, fe0;
      rv0 = n_rxv; tr0 = n_txr; fe0 = n_fe;
      lrck_in = 1'b0;
      repeat (60) @(posedge clk);
      lrck_in = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (n_rxv != rv0 || n_txr != tr0 || n_fe != fe0) begin
         failures++;
         $display("FAIL sclk_stop got pulses rxv=%0d txr=%0d fe=%0d want 0",
                  n_rxv - rv0, n_txr - tr0, n_fe - fe0);
      end
      checks++;
      if (rx_data_l !== 24'hABCDEF || rx_data_r !== 24'h123456) begin
         failures++;
         $display("FAIL sclk_stop_hold got %h/%h want abcdef/123456",
                  rx_data_l, rx_data_r);
      end
   endtask

   task automatic test_tx();
      int tr0;
      tx_data_l = 24'h800001;
      tx_data_r = 24'h7FFFFE;
      for (int f = 0; f < 2; f++) begin
         tr0 = n_txr;
         send_frame(24'h000000, 24'h000000, 32, 32);
         checks++;
         if (cap_l !== {24'h800001, 7'h00}) begin
            failures++;
            $display("FAIL tx_left%0d got %h want %h", f, cap_l, {24'h800001, 7'h00});
         end
         checks++;
         if (cap_r !== {24'h7FFFFE, 7'h00}) begin
            failures++;
            $display("FAIL tx_right%0d got %h want %h", f, cap_r, {24'h7FFFFE, 7'h00});
         end
         checks++;
         if (n_txr - tr0 != 1) begin
            failures++;
            $display("FAIL tx_ready%0d got %0d want 1", f, n_txr - tr0);
         end
      end
   endtask

   task automatic test_short_slot();
      int rv0, fe0;
      rv0 = n_rxv; fe0 = n_fe;
      send_frame(24'h0A0B0C, 24'h0D0E0F, 32, 16);
      checks++;
      if (n_rxv != rv0) begin
         failures++;
         $display("FAIL short_rxv got %0d want 0", n_rxv - rv0);
      end
      send_frame(24'h246813, 24'h975310, 32, 32);
      checks++;
      if (n_fe - fe0 != 1) begin
         failures++;
         $display("FAIL short_ferr got %0d want 1", n_fe - fe0);
      end
      checks++;
      if (n_rxv - rv0 != 1) begin
         failures++;
         $display("FAIL short_next_rxv got %0d want 1", n_rxv - rv0);
      end
      checks++;
      if (rx_data_l !== 24'h246813 || rx_data_r !== 24'h975310) begin
         failures++;
         $display("FAIL short_next_data got %h/%h want 246813/975310",
                  rx_data_l, rx_data_r);
      end
   endtask

   task automatic test_slot24();
      int fe0;
      fe0 = n_fe;
      send_frame(24'h5A5A5A, 24'hA5A5A5, 24, 24);
      send_frame(24'hC3C3C3, 24'h3C3C3C, 24, 24);
      checks++;
      if (rx_data_l !== 24'h5A5A5A || rx_data_r !== 24'hA5A5A5) begin
         failures++;
         $display("FAIL slot24_data got %h/%h want 5a5a5a/a5a5a5",
                  rx_data_l, rx_data_r);
      end
      tx_data_l = 24'h13579B;
      tx_data_r = 24'hECA864;
      loop = 1'b1;
      send_frame(24'h0, 24'h0, 24, 24);
      checks++;
      if (rx_data_l !== 24'hC3C3C3 || rx_data_r !== 24'h3C3C3C) begin
         failures++;
         $display("FAIL slot24_data2 got %h/%h want c3c3c3/3c3c3c",
                  rx_data_l, rx_data_r);
      end
      send_frame(24'h0, 24'h0, 24, 24);
      checks++;
      if (rx_data_l !== 24'h13579B || rx_data_r !== 24'hECA864) begin
         failures++;
         $display("FAIL loopback got %h/%h want 13579b/eca864",
                  rx_data_l, rx_data_r);
      end
      loop = 1'b0;
      checks++;
      if (n_fe != fe0) begin
         failures++;
         $display("FAIL slot24_ferr got %0d want 0", n_fe - fe0);
      end
   endtask

   task automatic test_reset_mid();
      int rv0, tr0;
      run_slot(1'b0, 24'h0, 32);
      run_slot(1'b1, 24'h0, 10);
      rst = 1'b0;
      #1;
      checks++;
      if (rx_data_l !== 24'h0 || rx_data_r !== 24'h0) begin
         failures++;
         $display("FAIL midrst_rx got %h/%h want 0/0", rx_data_l, rx_data_r);
      end
      checks++;
      if ({sdata_out, tx_ready, rx_valid, frame_err} !== 4'b0) begin
         failures++;
         $display("FAIL midrst_flags got %b want 0000",
                  {sdata_out, tx_ready, rx_valid, frame_err});
      end
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      rv0 = n_rxv; tr0 = n_txr;
      run_slot(1'b1, 24'hFFFFFF, 22);
      checks++;
      if (n_rxv != rv0 || n_txr != tr0 || cap_r !== 31'h0) begin
         failures++;
         $display("FAIL midrst_sync got rxv=%0d txr=%0d out=%h want 0 0 0",
                  n_rxv - rv0, n_txr - tr0, cap_r);
      end
      send_frame(24'h2468AC, 24'hFDB975, 32, 32);
      checks++;
      if (n_rxv - rv0 != 1) begin
         failures++;
         $display("FAIL midrst_rxv got %0d want 1", n_rxv - rv0);
      end
      checks++;
      if (rx_data_l !== 24'h2468AC || rx_data_r !== 24'hFDB975) begin
         failures++;
         $display("FAIL midrst_data got %h/%h want 2468ac/fdb975",
                  rx_data_l, rx_data_r);
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_rx_pattern();
      test_sclk_stop();
      test_tx();
      test_short_slot();
      test_slot24();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
